// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
// The state encodings are common to the top level and to any bench that inspects them.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } sw8_state_t;

    typedef enum logic {
        IDLE,
        WAIT
    } bus_state_t;

    // 5 ms at a 50 MHz board clock
    localparam int DEFAULT_DB_CYCLES = 250000;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side and core-side signals of the switch debouncer.
// Optional long-press output is present only when SWITCH_DEBOUNCER_LONGPRESS_EN is defined.
interface switch_debouncer_if #(
    parameter int n = 8
);
    logic         sw8_raw;
    logic [n-1:0] sws_raw;
    logic         sw8_level;
    logic         sw8_rise;
    logic         sw8_fall;
    logic [n-1:0] sws_stable;
    logic         sws_changed;
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
    logic         sw8_long;

    modport master (
        output sw8_raw, sws_raw,
        input  sw8_level, sw8_rise, sw8_fall, sws_stable, sws_changed, sw8_long
    );

    modport slave (
        input  sw8_raw, sws_raw,
        output sw8_level, sw8_rise, sw8_fall, sws_stable, sws_changed, sw8_long
    );
`else
    modport master (
        output sw8_raw, sws_raw,
        input  sw8_level, sw8_rise, sw8_fall, sws_stable, sws_changed
    );

    modport slave (
        input  sw8_raw, sws_raw,
        output sw8_level, sw8_rise, sw8_fall, sws_stable, sws_changed
    );
`endif
endinterface

// File: rtl/switch_debouncer_sync2.sv
// Two-flop synchroniser bringing asynchronous switch inputs into the clk domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises and debounces the step switch (sw8) and the data
// switch bus (sws), producing clean levels and single-cycle change pulses.
// Optional feature macro: SWITCH_DEBOUNCER_LONGPRESS_EN adds LONG_CYCLES and sw8_long.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int n         = 8,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
    ,
    parameter int LONG_CYCLES = 50000000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    switch_debouncer_if.slave bus
);

    localparam int             CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic         s8;
    logic [n-1:0] ss;

    sync2 #(.W(1)) u_sync_sw8 (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sw8_raw),
        .q     (s8)
    );

    sync2 #(.W(n)) u_sync_sws (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sws_raw),
        .q     (ss)
    );

    sw8_state_t       sw8_state, sw8_state_d;
    logic [CNT_W-1:0] sw8_cnt, sw8_cnt_d;
    logic             sw8_level_q, sw8_level_d;
    logic             sw8_rise_q, sw8_rise_d;
    logic             sw8_fall_q, sw8_fall_d;

    bus_state_t       bus_state, bus_state_d;
    logic [CNT_W-1:0] bus_cnt, bus_cnt_d;
    logic [n-1:0]     cand, cand_d;
    logic [n-1:0]     stable_q, stable_d;
    logic             changed_q, changed_d;

    // sw8 qualifier: a new level must hold for DB_CYCLES cycles; any reversion starts over.
    always_comb begin
        sw8_state_d = sw8_state;
        sw8_cnt_d   = sw8_cnt;
        sw8_level_d = sw8_level_q;
        sw8_rise_d  = 1'b0;
        sw8_fall_d  = 1'b0;
        case (sw8_state)
            IDLE_LO: begin
                if (s8) begin
                    sw8_state_d = WAIT_HI;
                    sw8_cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s8) begin
                    sw8_state_d = IDLE_LO;
                    sw8_cnt_d   = '0;
                end else if (sw8_cnt == CNT_LAST) begin
                    sw8_state_d = IDLE_HI;
                    sw8_cnt_d   = '0;
                    sw8_level_d = 1'b1;
                    sw8_rise_d  = 1'b1;
                end else begin
                    sw8_cnt_d = sw8_cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s8) begin
                    sw8_state_d = WAIT_LO;
                    sw8_cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s8) begin
                    sw8_state_d = IDLE_HI;
                    sw8_cnt_d   = '0;
                end else if (sw8_cnt == CNT_LAST) begin
                    sw8_state_d = IDLE_LO;
                    sw8_cnt_d   = '0;
                    sw8_level_d = 1'b0;
                    sw8_fall_d  = 1'b1;
                end else begin
                    sw8_cnt_d = sw8_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // sw8 state, counter and registered level/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw8_state   <= IDLE_LO;
            sw8_cnt     <= '0;
            sw8_level_q <= 1'b0;
            sw8_rise_q  <= 1'b0;
            sw8_fall_q  <= 1'b0;
        end else begin
            sw8_state   <= sw8_state_d;
            sw8_cnt     <= sw8_cnt_d;
            sw8_level_q <= sw8_level_d;
            sw8_rise_q  <= sw8_rise_d;
            sw8_fall_q  <= sw8_fall_d;
        end
    end

    // Bus qualifier: a differing candidate must hold unchanged for DB_CYCLES cycles.
    always_comb begin
        bus_state_d = bus_state;
        bus_cnt_d   = bus_cnt;
        cand_d      = cand;
        stable_d    = stable_q;
        changed_d   = 1'b0;
        case (bus_state)
            IDLE: begin
                if (ss != stable_q) begin
                    bus_state_d = WAIT;
                    cand_d      = ss;
                    bus_cnt_d   = '0;
                end
            end
            WAIT: begin
                if (ss == stable_q) begin
                    bus_state_d = IDLE;
                    bus_cnt_d   = '0;
                end else if (ss != cand) begin
                    cand_d    = ss;
                    bus_cnt_d = '0;
                end else if (bus_cnt == CNT_LAST) begin
                    bus_state_d = IDLE;
                    bus_cnt_d   = '0;
                    stable_d    = cand;
                    changed_d   = 1'b1;
                end else begin
                    bus_cnt_d = bus_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Bus state, candidate, counter and registered stable value/pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_state <= IDLE;
            bus_cnt   <= '0;
            cand      <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            bus_state <= bus_state_d;
            bus_cnt   <= bus_cnt_d;
            cand      <= cand_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    assign bus.sw8_level   = sw8_level_q;
    assign bus.sw8_rise    = sw8_rise_q;
    assign bus.sw8_fall    = sw8_fall_q;
    assign bus.sws_stable  = stable_q;
    assign bus.sws_changed = changed_q;

`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
    localparam int               LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt;
    logic              long_q;

    // Hold timer in IDLE_HI; saturates after one pulse so a held switch reports only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (sw8_state != IDLE_HI) begin
                long_cnt <= '0;
            end else if (long_cnt != LONG_SAT) begin
                long_cnt <= long_cnt + LONG_W'(1);
                if (long_cnt == LONG_LAST) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sw8_long = long_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (DB_CYCLES=4, n=8).
// Each accepted stimulus schedules its expected output events; a negedge monitor
// compares every pulse and level against the schedule each cycle.
// Define SWITCH_DEBOUNCER_LONGPRESS_EN to also cover sw8_long with LONG_CYCLES=10.
module tb_switch_debouncer;

    localparam int LAT  = 7;
    localparam int LONG = 10;
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
    localparam int NK = 4;
`else
    localparam int NK = 3;
`endif

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    ev_t        sb[$];
    logic       exp_level;
    logic [7:0] exp_stable;
    logic       tgt_level;
    logic [7:0] tgt_stable;
    logic       cur_sw8;
    logic [7:0] cur_sws;

    switch_debouncer_if #(.n(8)) dif ();

    switch_debouncer #(
        .n(8),
        .DB_CYCLES(4)
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
        ,
        .LONG_CYCLES(LONG)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic string kindName(input int k);
        case (k)
            0:       return "sw8_rise";
            1:       return "sw8_fall";
            2:       return "sws_changed";
            default: return "sw8_long";
        endcase
    endfunction

    function automatic int findEv(input int k, input int c);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].kind == k && sb[i].cyc == c) return i;
        return -1;
    endfunction

    // Queue events for whatever the currently held raw values will settle to.
    task automatic schedule();
        int c;
        c = cyc + LAT;
        if (cur_sw8 != tgt_level) begin
            sb.push_back('{kind: (cur_sw8 ? 0 : 1), cyc: c, val: 8'h00});
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
            if (cur_sw8) sb.push_back('{kind: 3, cyc: c + LONG, val: 8'h00});
`endif
            tgt_level = cur_sw8;
        end
        if (cur_sws != tgt_stable) begin
            sb.push_back('{kind: 2, cyc: c, val: cur_sws});
            tgt_stable = cur_sws;
        end
    endtask

    task automatic applyStimulus(input logic sw8v, input logic [7:0] swsv, input bit accept);
        @(posedge clk);
        #2;
        if (cur_sw8 && !sw8v) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].kind == 3 && sb[i].cyc > cyc + 3) sb.delete(i);
        end
        dif.sw8_raw = sw8v;
        dif.sws_raw = swsv;
        cur_sw8     = sw8v;
        cur_sws     = swsv;
        if (accept) schedule();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        schedule();
    endtask

    task automatic applyReset(input int n_cycles);
        @(posedge clk);
        #2;
        reset      = 1'b1;
        sb.delete();
        exp_level  = 1'b0;
        exp_stable = 8'h00;
        tgt_level  = 1'b0;
        tgt_stable = 8'h00;
        repeat (n_cycles) @(posedge clk);
        releaseReset();
    endtask

    task automatic waitCycles(input int n_cycles);
        repeat (n_cycles) @(posedge clk);
    endtask

    // Per-cycle monitor: each pulse must match a scheduled event; levels follow the schedule.
    always @(negedge clk) begin
        logic [3:0] obs;
        int         idx;
        obs = {1'b0, dif.sws_changed, dif.sw8_fall, dif.sw8_rise};
`ifdef SWITCH_DEBOUNCER_LONGPRESS_EN
        obs[3] = dif.sw8_long;
`endif
        for (int k = 0; k < NK; k++) begin
            idx = findEv(k, cyc);
            if (idx >= 0) begin
                if (k == 0) exp_level = 1'b1;
                if (k == 1) exp_level = 1'b0;
                if (k == 2) exp_stable = sb[idx].val;
                sb.delete(idx);
            end
            checkOutput(kindName(k), 32'(obs[k]), 32'(idx >= 0));
        end
        checkOutput("sw8_level", 32'(dif.sw8_level), 32'(exp_level));
        checkOutput("sws_stable", 32'(dif.sws_stable), 32'(exp_stable));
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_level  = 1'b0;
        exp_stable = 8'h00;
        tgt_level  = 1'b0;
        tgt_stable = 8'h00;
        reset      = 1'b1;
        cur_sw8    = 1'b1;
        cur_sws    = 8'hA5;
        dif.sw8_raw = 1'b1;
        dif.sws_raw = 8'hA5;

        $display("[TB] reset with inputs held high");
        waitCycles(3);
        releaseReset();
        waitCycles(10);

        $display("[TB] clean fall, rise, fall on sw8");
        applyStimulus(1'b0, 8'hA5, 1'b1);
        waitCycles(10);
        applyStimulus(1'b1, 8'hA5, 1'b1);
        waitCycles(10);
        applyStimulus(1'b0, 8'hA5, 1'b1);
        waitCycles(10);

        $display("[TB] bouncing sw8 press");
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2) == 0, 8'hA5, 1'b0);
            waitCycles(1);
        end
        applyStimulus(1'b1, 8'hA5, 1'b1);
        waitCycles(10);

        $display("[TB] data bus change with candidate replacement and glitch");
        applyStimulus(1'b1, 8'h00, 1'b1);
        waitCycles(10);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 8'h3D, 1'b1);
        waitCycles(10);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h3D, 1'b1);
        waitCycles(10);

        $display("[TB] reset during sw8 qualification");
        applyStimulus(1'b0, 8'h3D, 1'b1);
        waitCycles(10);
        applyStimulus(1'b1, 8'h3D, 1'b1);
        waitCycles(4);
        applyReset(2);
        waitCycles(10);

        $display("[TB] long hold");
        waitCycles(25);
        applyStimulus(1'b0, 8'h3D, 1'b1);
        waitCycles(12);

        checkOutput("pending_events", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
